// File: rtl/t_ff_counter.sv
// t_ff_counter: WIDTH-bit bank of T flip-flops.
// Modes: hold, per-bit toggle, chained up/down count, parallel load.
module t_ff_counter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_COUNT  = 2'b10,
        MODE_LOAD   = 2'b11
    } mode_e;

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] chain_t;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             and_acc, nor_acc;
    logic             at_term;

    assign mode_s = mode_e'(mode);

    // Ripple toggle chain: bit i toggles when all lower bits are
    // at the terminal level for the current direction.
    always_comb begin
        chain_t    = '0;
        chain_t[0] = 1'b1;
        and_acc    = q_q[0];
        nor_acc    = ~q_q[0];
        for (int i = 1; i < WIDTH; i++) begin
            chain_t[i] = up ? and_acc : nor_acc;
            and_acc    = and_acc & q_q[i];
            nor_acc    = nor_acc & ~q_q[i];
        end
        at_term = up ? and_acc : nor_acc;
    end

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        sat_d  = sat_q;
        unique case (mode_s)
            MODE_HOLD: begin
                q_d = q_q;
            end
            MODE_TOGGLE: begin
                q_d   = q_q ^ t;
                sat_d = 1'b0;
            end
            MODE_COUNT: begin
                if (at_term && SATURATE) begin
                    sat_d = 1'b1;
                end else begin
                    q_d    = q_q ^ chain_t;
                    wrap_d = at_term;
                    sat_d  = 1'b0;
                end
            end
            MODE_LOAD: begin
                q_d   = d;
                sat_d = 1'b0;
            end
            default: begin
                q_d = q_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= RESET_VAL;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
    assign tc   = (mode_s == MODE_COUNT) && at_term;
    assign wrap = wrap_q;
    assign sat  = sat_q;

endmodule

// File: tb/tb_t_ff_counter.sv
// Self-checking bench for t_ff_counter: wrap, saturating and 1-bit
// instances share stimulus; expected results are queued per edge.
module tb_t_ff_counter;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] TOG  = 2'b01;
    localparam logic [1:0] CNT  = 2'b10;
    localparam logic [1:0] LOAD = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = HOLD;
    logic [7:0] t = '0;
    logic       up = 1'b1;
    logic [7:0] d = '0;

    logic [7:0] q0, qb0, q1, qb1;
    logic       tc0, wr0, sa0, tc1, wr1, sa1;
    logic [0:0] q2, qb2;
    logic       tc2, wr2, sa2;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] qb;
        logic       wrap;
        logic       sat;
        logic       tc;
    } obs_t;

    obs_t expq[$];
    obs_t obsq[$];

    always #5 clk = ~clk;

    t_ff_counter #(.WIDTH(8), .SATURATE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .mode(mode), .t(t), .up(up), .d(d),
        .q(q0), .qbar(qb0), .tc(tc0), .wrap(wr0), .sat(sa0)
    );

    t_ff_counter #(.WIDTH(8), .SATURATE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .mode(mode), .t(t), .up(up), .d(d),
        .q(q1), .qbar(qb1), .tc(tc1), .wrap(wr1), .sat(sa1)
    );

    t_ff_counter #(.WIDTH(1), .SATURATE(1'b0)) dut2 (
        .clk(clk), .reset(reset), .mode(mode), .t(t[0:0]), .up(up),
        .d(d[0:0]), .q(q2), .qbar(qb2), .tc(tc2), .wrap(wr2), .sat(sa2)
    );

    function automatic obs_t sample(int w);
        obs_t o;
        case (w)
            0:       o = '{q0, qb0, wr0, sa0, tc0};
            1:       o = '{q1, qb1, wr1, sa1, tc1};
            default: o = '{{7'b0, q2}, {7'h7F, qb2}, wr2, sa2, tc2};
        endcase
        return o;
    endfunction

    // Drive one cycle of stimulus, queue its expected outcome,
    // then capture what the chosen instance shows after the edge.
    task automatic drv(input int w, input logic [1:0] m, input logic u,
                       input logic [7:0] tv, input logic [7:0] dv,
                       input logic [7:0] eq, input logic ew,
                       input logic es, input logic etc);
        mode = m;
        up   = u;
        t    = tv;
        d    = dv;
        expq.push_back('{eq, ~eq, ew, es, etc});
        @(posedge clk);
        #1;
        obsq.push_back(sample(w));
    endtask

    task automatic test_reset;
        obs_t e, o;
        int   n = 0;
        #2 reset = 1'b0;
        drv(0, LOAD, 1, 8'h00, 8'h3C, 8'h00, 0, 0, 0);
        reset = 1'b1;
        drv(0, HOLD, 1, 8'h00, 8'h3C, 8'h00, 0, 0, 0);
        drv(0, HOLD, 1, 8'h00, 8'h3C, 8'h00, 0, 0, 0);
        drv(0, HOLD, 1, 8'h00, 8'h3C, 8'h00, 0, 0, 0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset step %0d: got %p want %p", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_toggle;
        obs_t e, o;
        int   n = 0;
        drv(0, TOG, 1, 8'hA5, 8'h00, 8'hA5, 0, 0, 0);
        drv(0, TOG, 1, 8'hA5, 8'h00, 8'h00, 0, 0, 0);
        drv(0, TOG, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        drv(0, TOG, 1, 8'h0F, 8'h00, 8'h0F, 0, 0, 0);
        drv(0, TOG, 0, 8'h81, 8'h00, 8'h8E, 0, 0, 0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL toggle step %0d: got %p want %p", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_up_wrap;
        obs_t e, o;
        int   n = 0;
        drv(0, LOAD, 1, 8'h00, 8'hFE, 8'hFE, 0, 0, 0);
        drv(0, CNT, 1, 8'h00, 8'h00, 8'hFF, 0, 0, 1);
        drv(0, CNT, 1, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        drv(0, CNT, 1, 8'h00, 8'h00, 8'h01, 0, 0, 0);
        drv(0, CNT, 1, 8'h00, 8'h00, 8'h02, 0, 0, 0);
        drv(0, LOAD, 1, 8'h00, 8'hFF, 8'hFF, 0, 0, 0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL up_wrap step %0d: got %p want %p", n, o, e);
            end
            n++;
        end
        mode = CNT;
        up   = 1'b1;
        #1;
        checks++;
        if (tc0 !== 1'b1) begin
            errors++;
            $display("FAIL tc_after_load: got %b want 1", tc0);
        end
    endtask

    task automatic test_down;
        obs_t e, o;
        int   n = 0;
        drv(0, LOAD, 0, 8'h00, 8'h01, 8'h01, 0, 0, 0);
        drv(0, CNT, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
        drv(0, CNT, 0, 8'h00, 8'h00, 8'hFF, 1, 0, 0);
        drv(0, CNT, 0, 8'h00, 8'h00, 8'hFE, 0, 0, 0);
        drv(0, HOLD, 0, 8'h00, 8'h00, 8'hFE, 0, 0, 0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL down step %0d: got %p want %p", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_saturate;
        obs_t e, o;
        int   n = 0;
        drv(1, LOAD, 1, 8'h00, 8'hFE, 8'hFE, 0, 0, 0);
        drv(1, CNT, 1, 8'h00, 8'h00, 8'hFF, 0, 0, 1);
        drv(1, CNT, 1, 8'h00, 8'h00, 8'hFF, 0, 1, 1);
        drv(1, CNT, 1, 8'h00, 8'h00, 8'hFF, 0, 1, 1);
        drv(1, HOLD, 1, 8'h00, 8'h00, 8'hFF, 0, 1, 0);
        drv(1, CNT, 0, 8'h00, 8'h00, 8'hFE, 0, 0, 0);
        drv(1, CNT, 1, 8'h00, 8'h00, 8'hFF, 0, 0, 1);
        drv(1, CNT, 1, 8'h00, 8'h00, 8'hFF, 0, 1, 1);
        drv(1, TOG, 1, 8'h00, 8'h00, 8'hFF, 0, 0, 0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL saturate step %0d: got %p want %p", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_async_reset;
        obs_t e, o;
        int   n = 0;
        drv(0, LOAD, 1, 8'h00, 8'h7D, 8'h7D, 0, 0, 0);
        drv(0, CNT, 1, 8'h00, 8'h00, 8'h7E, 0, 0, 0);
        drv(0, CNT, 1, 8'h00, 8'h00, 8'h7F, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({q0, qb0, wr0, sa0} !== {8'h00, 8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_mid: got q=%h qbar=%h wrap=%b sat=%b want 00 ff 0 0",
                     q0, qb0, wr0, sa0);
        end
        reset = 1'b1;
        drv(0, CNT, 1, 8'h00, 8'h00, 8'h01, 0, 0, 0);
        drv(0, LOAD, 1, 8'h00, 8'hFF, 8'hFF, 0, 0, 0);
        drv(0, CNT, 1, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (wr0 !== 1'b0) begin
            errors++;
            $display("FAIL async_wrap_clear: got wrap=%b want 0", wr0);
        end
        reset = 1'b1;
        drv(0, CNT, 1, 8'h00, 8'h00, 8'h01, 0, 0, 0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL async step %0d: got %p want %p", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_width1;
        obs_t e, o;
        int   n = 0;
        drv(2, LOAD, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        drv(2, CNT, 1, 8'h00, 8'h00, 8'h01, 0, 0, 1);
        drv(2, CNT, 1, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        drv(2, CNT, 0, 8'h00, 8'h00, 8'h01, 1, 0, 0);
        drv(2, CNT, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
        drv(2, TOG, 0, 8'h01, 8'h00, 8'h01, 0, 0, 0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL width1 step %0d: got %p want %p", n, o, e);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_up_wrap();
        test_down();
        test_saturate();
        test_async_reset();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/t_ff_counter.md
Name: t_ff_counter

Overview:
- Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit bank of T flip-flops with a mode select.
- Modes: per-bit toggle (independent T inputs), chained up/down counting (T-input chain), parallel load, hold.
- Serves as the shared register/counter primitive for the library's timer, divider and debounce blocks.
- Complementary outputs are kept for compatibility with existing single-bit T flip-flop users.

Parameters:
- WIDTH, 8, number of flip-flops in the bank (legal range 1..32).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- SATURATE, 0, count-mode overflow policy: 0 = wrap around, 1 = stick at the terminal value.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- mode  input  2  00 HOLD, 01 TOGGLE, 10 COUNT, 11 LOAD.
- t  input  WIDTH  per-bit toggle enables, used in TOGGLE mode.
- up  input  1  count direction in COUNT mode: 1 = up, 0 = down.
- d  input  WIDTH  parallel load data, used in LOAD mode.
- q  output  WIDTH  flip-flop state.
- qbar  output  WIDTH  always ~q.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse on a count wrap-around.
- sat  output  1  registered level: counter is held at its terminal value (SATURATE=1 only).

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - q=RESET_VAL, qbar=~RESET_VAL, wrap=0, sat=0.
  - Release is synchronous in effect: the first update happens on the first rising clk edge with reset=1.
  - Reset asserted mid-count overrides any mode immediately.
- All state updates occur on the rising clk edge; q reflects the new value one cycle after inputs are sampled.
- HOLD (00): q unchanged; wrap <= 0; sat unchanged.
- TOGGLE (01): q <= q ^ t. Bits with t=0 hold. wrap <= 0; sat <= 0.
- COUNT (10):
  - Internal toggle chain, equivalent to q±1 modulo 2^WIDTH.
    - Up: T[0]=1, T[i]=&q[i-1:0].
    - Down: T[0]=1, T[i]=~|q[i-1:0].
  - Terminal value: all ones when up=1, all zeros when up=0.
  - tc = (mode==COUNT) && q==terminal; otherwise tc=0.
  - At terminal with SATURATE=0: q wraps (all ones -> 0 up, 0 -> all ones down); wrap <= 1 for exactly the cycle after the wrapping edge.
  - At terminal with SATURATE=1: q holds; sat <= 1; wrap stays 0.
  - Not at terminal: q steps by ±1; wrap <= 0; sat <= 0.
  - Changing up while at a value that is terminal only for the old direction counts normally, and sat clears.
- LOAD (11): q <= d; wrap <= 0; sat <= 0. Loading the terminal value then entering COUNT sets tc in the same cycle.
- WIDTH=1: COUNT mode behaves as a plain T flip-flop with T=1. tc = q when up=1, ~q when up=0.
- No undefined states: every mode/input combination has a defined next state. X on mode is not required to be tolerated.

Test Plan:
- Reset/hold: reset=0 with d=8'h3C, mode=LOAD -> q=00, qbar=FF, wrap=0. Release, mode=HOLD 3 cycles -> q stays 00.
- Toggle: from q=00, mode=TOGGLE, t=8'hA5 -> q=A5, qbar=5A. Second edge -> q=00. t=00 -> q holds.
- Up wrap (SATURATE=0): load FE, COUNT up=1 -> q=FF with tc=1, then q=00 with wrap=1 for one cycle, then q=01 with wrap=0.
- Saturate (SATURATE=1): load FE, COUNT up=1 -> q=FF, stays FF, sat=1. Switch up=0 -> q=FE, sat=0.
- Down count: load 01, COUNT up=0 -> q=00 (tc=1), then FF with wrap=1 (SATURATE=0).
- Async reset mid-count: counting up at q=7F, drop reset between clock edges -> q=RESET_VAL immediately, wrap=0. Release -> counting resumes from RESET_VAL.
